// File: rtl/ctx_pkg.sv
// Shared constants for the context-switch controller.
// FSM encodings plus the changeProcess/troca_contexto codes.
package ctx_pkg;

  localparam logic [1:0] OCIOSO     = 2'b00;
  localparam logic [1:0] EXECUTANDO = 2'b01;
  localparam logic [1:0] TROCA      = 2'b10;
  localparam logic [1:0] IO         = 2'b11;

  localparam logic [1:0] TROCA_ESCALONADOR = 2'b11;
  localparam logic [1:0] DESPACHO          = 2'b01;

endpackage

// File: rtl/context_switch_controller_quantum_counter.sv
// Loadable quantum down-counter with hold; never wraps below zero.
// Ports: clock, reset (sync, active-low), load/loadValue, dec, count, isZero, isOne.
module quantum_counter
  import ctx_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             isZero,
  output logic             isOne
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && !isZero) begin
      count <= count - WIDTH'(1);
    end
  end

  assign isZero = (count == '0);
  assign isOne  = (count == WIDTH'(1));

endmodule

// File: rtl/context_switch_controller.sv
// Preemption source: quantum timer + I/O request latch driving context switches.
// Ports: clock/reset, habilita, change_process, pid_in, quantum_in, parada, io_req, pc_atual -> requests, captures, counter.
module context_switch_controller
  import ctx_pkg::*;
#(
  parameter int LARGURA_QUANTUM = 16,
  parameter int QUANTUM_PADRAO  = 1000,
  parameter int LARGURA_PID     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       habilita,
  input  logic [1:0]                 change_process,
  input  logic [LARGURA_PID-1:0]     pid_in,
  input  logic [LARGURA_QUANTUM-1:0] quantum_in,
  input  logic                       parada,
  input  logic                       io_req,
  input  logic [31:0]                pc_atual,
  output logic [1:0]                 troca_contexto,
  output logic                       instrucao_io_contexto,
  output logic [31:0]                pc_salvo,
  output logic [LARGURA_PID-1:0]     pid_interrompido,
  output logic [LARGURA_QUANTUM-1:0] quantum_restante,
  output logic                       io_pendente
);

  logic [1:0]                 state;
  logic [1:0]                 nextState;
  logic [LARGURA_PID-1:0]     pidReg;
  logic                       dispatch;
  logic                       load;
  logic                       dec;
  logic                       isZero;
  logic                       isOne;
  logic [LARGURA_QUANTUM-1:0] loadValue;

  assign dispatch  = (change_process == DESPACHO);
  assign loadValue = (quantum_in == '0) ?
                     LARGURA_QUANTUM'(QUANTUM_PADRAO) : quantum_in;

  quantum_counter #(
    .WIDTH(LARGURA_QUANTUM)
  ) uCounter (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .loadValue(loadValue),
    .dec      (dec),
    .count    (quantum_restante),
    .isZero   (isZero),
    .isOne    (isOne)
  );

  // The counter still ticks on the edge that diverts to IO, so an
  // I/O request landing on the 1->0 edge leaves the counter at 0.
  always_comb begin
    nextState = state;
    load      = 1'b0;
    dec       = 1'b0;
    unique case (1'b1)
      (state == OCIOSO): begin
        if (dispatch) begin
          load = 1'b1;
          if (habilita) nextState = EXECUTANDO;
        end
      end
      (state == EXECUTANDO): begin
        if (!habilita) begin
          nextState = OCIOSO;
        end else if (io_pendente || io_req) begin
          nextState = IO;
          dec       = !parada && !isZero;
        end else if (dispatch) begin
          load = 1'b1;
        end else begin
          dec = !parada && !isZero;
          if (isOne && !parada) nextState = TROCA;
        end
      end
      default: nextState = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                 <= OCIOSO;
      pidReg                <= '0;
      troca_contexto        <= 2'b00;
      instrucao_io_contexto <= 1'b0;
      pc_salvo              <= '0;
      pid_interrompido      <= '0;
      io_pendente           <= 1'b0;
    end else begin
      state                 <= nextState;
      troca_contexto        <= (nextState == TROCA) ?
                               TROCA_ESCALONADOR : 2'b00;
      instrucao_io_contexto <= (nextState == IO);
      if (load) pidReg <= pid_in;
      // The CPU overwrites pc during the request cycle, so the
      // return PC is the one seen while the request is active.
      if (state == TROCA || state == IO) begin
        pc_salvo         <= pc_atual;
        pid_interrompido <= pidReg;
      end
      if (nextState == IO) begin
        io_pendente <= 1'b0;
      end else if (io_req) begin
        io_pendente <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_context_switch_controller.sv
// Directed vector bench for context_switch_controller.
// Table of per-cycle vectors plus hand sequences for long/multi-cycle cases.
module tb_context_switch_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilita;
  logic [1:0]  change_process;
  logic [7:0]  pid_in;
  logic [15:0] quantum_in;
  logic        parada;
  logic        io_req;
  logic [31:0] pc_atual;
  logic [1:0]  troca_contexto;
  logic        instrucao_io_contexto;
  logic [31:0] pc_salvo;
  logic [7:0]  pid_interrompido;
  logic [15:0] quantum_restante;
  logic        io_pendente;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  context_switch_controller dut (
    .clock                (clock),
    .reset                (reset),
    .habilita             (habilita),
    .change_process       (change_process),
    .pid_in               (pid_in),
    .quantum_in           (quantum_in),
    .parada               (parada),
    .io_req               (io_req),
    .pc_atual             (pc_atual),
    .troca_contexto       (troca_contexto),
    .instrucao_io_contexto(instrucao_io_contexto),
    .pc_salvo             (pc_salvo),
    .pid_interrompido     (pid_interrompido),
    .quantum_restante     (quantum_restante),
    .io_pendente          (io_pendente)
  );

  typedef struct {
    logic        h;
    logic [1:0]  cp;
    logic [7:0]  pid;
    logic [15:0] q;
    logic        par;
    logic        io;
    logic [31:0] pc;
    logic [1:0]  eTroca;
    logic        eIo;
    logic [31:0] ePc;
    logic [7:0]  ePid;
    logic [15:0] eQ;
    logic        ePend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic h, input logic [1:0] cp, input logic [7:0] pid,
    input logic [15:0] q, input logic par, input logic io,
    input logic [31:0] pc, input logic [1:0] eTroca, input logic eIo,
    input logic [31:0] ePc, input logic [7:0] ePid,
    input logic [15:0] eQ, input logic ePend);
    vec_t v;
    v.h = h; v.cp = cp; v.pid = pid; v.q = q; v.par = par;
    v.io = io; v.pc = pc; v.eTroca = eTroca; v.eIo = eIo;
    v.ePc = ePc; v.ePid = ePid; v.eQ = eQ; v.ePend = ePend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [1:0] eT,
                          input logic eI, input logic [31:0] ePc,
                          input logic [7:0] ePid, input logic [15:0] eQ,
                          input logic eP);
    check({tag, " troca"}, 32'(troca_contexto), 32'(eT));
    check({tag, " io"}, 32'(instrucao_io_contexto), 32'(eI));
    check({tag, " pc_salvo"}, pc_salvo, ePc);
    check({tag, " pid_int"}, 32'(pid_interrompido), 32'(ePid));
    check({tag, " quantum"}, 32'(quantum_restante), 32'(eQ));
    check({tag, " io_pend"}, 32'(io_pendente), 32'(eP));
  endtask

  initial begin
    int n;
    // Quantum 4 run to expiry
    vecs.push_back(mk(1,2'b01,5,4,0,0,32'h100, 0,0,0,0,4,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h104, 0,0,0,0,3,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h108, 0,0,0,0,2,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h10c, 0,0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h110, 2'b11,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h200, 0,0,32'h200,5,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h204, 0,0,32'h200,5,0,0));
    // I/O pulse at counter 7
    vecs.push_back(mk(1,2'b01,9,10,0,0,32'h0, 0,0,32'h200,5,10,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h200,5,9,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h200,5,8,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h200,5,7,0));
    vecs.push_back(mk(1,0,0,0,0,1,32'h300, 0,1,32'h200,5,6,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h304, 0,0,32'h304,9,6,0));
    // I/O on the 1->0 edge: IO wins
    vecs.push_back(mk(1,2'b01,3,3,0,0,32'h0, 0,0,32'h304,9,3,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h304,9,2,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h304,9,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,32'h0, 0,1,32'h304,9,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h400, 0,0,32'h400,3,0,0));
    // I/O while idle: sticky, serviced after dispatch
    vecs.push_back(mk(1,0,0,0,0,1,32'h0, 0,0,32'h400,3,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h400,3,0,1));
    vecs.push_back(mk(1,2'b01,7,5,0,0,32'h0, 0,0,32'h400,3,5,1));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,1,32'h400,3,4,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h500, 0,0,32'h500,7,4,0));
    // Disabled dispatch: counter loads but never runs
    vecs.push_back(mk(0,2'b01,2,2,0,0,32'h0, 0,0,32'h500,7,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 0,0,32'h500,7,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 0,0,32'h500,7,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 0,0,32'h500,7,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 0,0,32'h500,7,2,0));
    // Redispatch at counter 2
    vecs.push_back(mk(1,2'b01,4,5,0,0,32'h0, 0,0,32'h500,7,5,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h500,7,4,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h500,7,3,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h500,7,2,0));
    vecs.push_back(mk(1,2'b01,6,8,0,0,32'h0, 0,0,32'h500,7,8,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,0,32'h500,7,7,0));

    reset = 1'b0; habilita = 1'b0; change_process = 2'b00;
    pid_in = '0; quantum_in = '0; parada = 1'b0;
    io_req = 1'b1; pc_atual = 32'hdead;
    tick();
    tick();
    checkAll("rst", 0, 0, 0, 0, 0, 0);
    reset = 1'b1; io_req = 1'b0;
    tick();
    checkAll("post_rst", 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      habilita = vecs[i].h; change_process = vecs[i].cp;
      pid_in = vecs[i].pid; quantum_in = vecs[i].q;
      parada = vecs[i].par; io_req = vecs[i].io;
      pc_atual = vecs[i].pc;
      tick();
      checkAll($sformatf("v%0d", i), vecs[i].eTroca, vecs[i].eIo,
               vecs[i].ePc, vecs[i].ePid, vecs[i].eQ, vecs[i].ePend);
    end
    change_process = 2'b00; io_req = 1'b0;

    // Reloaded quantum 8 (now 7) expires after 7 more edges
    n = 0;
    while (troca_contexto !== 2'b11 && n < 50) begin
      tick();
      n++;
    end
    check("redispatch_expiry", 32'(n), 32'd7);
    check("redispatch_q0", 32'(quantum_restante), 32'd0);
    pc_atual = 32'h600;
    tick();
    check("redispatch_pid", 32'(pid_interrompido), 32'd6);
    check("redispatch_pc", pc_salvo, 32'h600);
    check("redispatch_off", 32'(troca_contexto), 32'd0);

    // Default quantum with a 10-cycle stall
    change_process = 2'b01; pid_in = 8'd8; quantum_in = '0;
    tick();
    change_process = 2'b00;
    check("default_q", 32'(quantum_restante), 32'd1000);
    for (int i = 0; i < 100; i++) tick();
    check("q_before_stall", 32'(quantum_restante), 32'd900);
    parada = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("q_after_stall", 32'(quantum_restante), 32'd900);
    parada = 1'b0;
    n = 110;
    while (troca_contexto !== 2'b11 && n < 1200) begin
      tick();
      n++;
    end
    check("stall_expiry", 32'(n), 32'd1010);
    tick();
    check("stall_pid", 32'(pid_interrompido), 32'd8);

    // Reset while the switch request is active
    change_process = 2'b01; pid_in = 8'd1; quantum_in = 16'd1;
    tick();
    change_process = 2'b00;
    tick();
    check("rst_troca_pre", 32'(troca_contexto), 32'd3);
    reset = 1'b0;
    tick();
    check("rst_troca_req", 32'(troca_contexto), 32'd0);
    check("rst_troca_pc", pc_salvo, 32'd0);
    check("rst_troca_pid", 32'(pid_interrompido), 32'd0);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
